data_storer: RTL
================

// Module: data_storer
// PURPOSE
//  Store path of the MEM stage, the write-side counterpart of the load-data formatter. Accepts one
//  store (SB/SH/SW) per request, decodes target (base SRAM, ext SRAM, UART), aligns data onto byte lanes,
//  generates active-low byte enables and sequences SRAM / UART write strobes. Pulses done (err on fault).
// PARAMETERS
//  WE_CYCLES   1             number of cycles ram_we_n is held low (>=1)
//  UART_ADDR   32'h10000000  UART data register address (byte store only)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous active-high reset
//  req_valid      in   1   store request present
//  req_ready      out  1   block idle, request accepted when req_valid & req_ready
//  req_addr       in   32  byte address of store
//  req_data       in   32  store data, right-aligned (rs2)
//  req_size       in   2   2'b00 byte, 2'b01 half, 2'b10 word; 2'b11 illegal
//  done           out  1   one-cycle pulse: store finished (or faulted)
//  err            out  1   valid with done: misaligned/unmapped/illegal size, no bus write done
//  mem_use        out  2   `USE_BASE / `USE_EXT / `USE_UART of the active store
//  ram_addr       out  20  word address = req_addr[21:2]
//  ram_wdata      out  32  lane-replicated store data
//  ram_be_n       out  4   active-low byte enables (`BE_WORD, `BE_BYTE_0..3, halves 4'b1100/4'b0011)
//  ram_ce_n       out  1   chip enable of selected SRAM (mem_use tells which)
//  ram_we_n       out  1   write strobe
//  ram_oe_n       out  1   output enable, held 1 by this block
//  uart_tx_ready  in   1   UART transmitter can accept a byte
//  uart_wr_n      out  1   UART write strobe
//  uart_wdata     out  8   byte to UART = req_data[7:0]
// BEHAVIOUR
//  - All outputs registered except req_ready = (state==IDLE).
//  - Reset (any state, incl. mid-write): state IDLE; ram_ce_n=ram_we_n=ram_oe_n=1, ram_be_n=4'b1111,
//    uart_wr_n=1, done=0, err=0, mem_use=`USE_BASE, ram_addr/ram_wdata/uart_wdata=0. Next cycle idle.
//  - Decode at acceptance: 0x8000_0000-0x803F_FFFF base, 0x8040_0000-0x807F_FFFF ext,
//    addr==UART_ADDR uart (size must be byte); anything else -> fault.
//  - Alignment: half requires addr[0]==0, word requires addr[1:0]==0; violation or size 2'b11 -> fault.
//  - Lanes: byte -> wdata={4{d[7:0]}}, be_n=~(4'b0001<<addr[1:0]); half -> {2{d[15:0]}},
//    be_n= addr[1]?4'b0011:4'b1100; word -> d, be_n=4'b0000.
//  - States: IDLE, SETUP, WRITE, HOLD, U_WAIT, U_WR, U_HOLD, FAULT.
//  - IDLE: on accept latch addr/data/be/mem_use; -> SETUP (SRAM), U_WAIT (UART), FAULT (fault).
//  - SETUP (1 cyc): ce_n=0, we_n=1, addr/data/be stable. -> WRITE.
//  - WRITE (WE_CYCLES cyc, counter): ce_n=0, we_n=0. -> HOLD.
//  - HOLD (1 cyc): ce_n=0, we_n=1, done=1. -> IDLE (ce_n=1, be_n=1111 on exit).
//  - SRAM latency: done asserted 2+WE_CYCLES cycles after the accepting edge; next accept earliest in
//    cycle after done (throughput 1 store per 3+WE_CYCLES cycles).
//  - U_WAIT: stay while uart_tx_ready=0 (unbounded); -> U_WR when 1.
//  - U_WR (1 cyc): uart_wr_n=0, uart_wdata stable. U_HOLD (1 cyc): uart_wr_n=1, done=1. -> IDLE.
//  - FAULT (1 cyc): done=1, err=1, no strobe ever asserts. -> IDLE.
//  - req_valid while not IDLE is ignored (req_ready=0); inputs sampled only at accept.
//  - ram_we_n and uart_wr_n never low simultaneously; ram_we_n only low with ram_ce_n low.
// TESTING
//  - SW 0x8000_0010 data 0xDEADBEEF -> ram_addr 0x00004, be_n 0000, wdata DEADBEEF, we_n low 1 cyc, done at +3.
//  - SB 0x8040_0003 data 0x000000A5 -> mem_use ext, be_n 0111, wdata A5A5A5A5, done at +3.
//  - SH 0x8000_0002 data 0x1234 -> be_n 0011, wdata 12341234; SH 0x8000_0001 -> done+err at +1, we_n stays 1.
//  - SB UART_ADDR data 0x41, uart_tx_ready low 5 cyc -> uart_wr_n low 1 cyc after ready, wdata 0x41, done next.
//  - SW 0x0000_1000 (unmapped) -> done=1 err=1 at +1, ce_n/we_n/uart_wr_n stay 1.
//  - rst in WRITE with WE_CYCLES=3 -> next cycle we_n=ce_n=1, be_n=1111, no done, req_ready=1.

Source files
------------

// File: rtl/data_storer_if.sv
// ============================================================================
//  Module   : data_storer_if
//  Purpose  : Store request handshake plus SRAM / UART write-side bus bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface data_storer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [1:0]  mem_use;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_we_n;
    logic        ram_oe_n;
    logic        uart_tx_ready;
    logic        uart_wr_n;
    logic [7:0]  uart_wdata;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, uart_tx_ready,
        output req_ready, done, err, mem_use, ram_addr, ram_wdata, ram_be_n,
               ram_ce_n, ram_we_n, ram_oe_n, uart_wr_n, uart_wdata
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, uart_tx_ready,
        input  req_ready, done, err, mem_use, ram_addr, ram_wdata, ram_be_n,
               ram_ce_n, ram_we_n, ram_oe_n, uart_wr_n, uart_wdata
    );
endinterface

`default_nettype wire

// File: rtl/data_storer.sv
// ============================================================================
//  Module   : data_storer
//  Purpose  : MEM-stage store path: decode, lane alignment, SRAM/UART strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_storer #(
    parameter int          WE_CYCLES = 1,
    parameter logic [31:0] UART_ADDR = 32'h1000_0000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    data_storer_if.slave bus
);
    localparam logic [1:0] c_USE_BASE = 2'd0;
    localparam logic [1:0] c_USE_EXT  = 2'd1;
    localparam logic [1:0] c_USE_UART = 2'd2;

    localparam int c_CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WRITE, S_HOLD, S_U_WAIT, S_U_WR, S_U_HOLD, S_FAULT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [19:0]        r_addr, w_addr_nxt;
    logic [31:0]        r_wdata, w_wdata_nxt;
    logic [3:0]         r_be_n, w_be_n_nxt;
    logic [7:0]         r_uwdata, w_uwdata_nxt;
    logic [1:0]         r_use, w_use_nxt;
    logic               r_ce_n, r_we_n, r_wr_n, r_done, r_err;
    logic               w_ce_n_nxt, w_we_n_nxt, w_wr_n_nxt, w_done_nxt, w_err_nxt;

    logic               w_in_base, w_in_ext, w_is_uart, w_aligned, w_fault;
    logic [31:0]        w_lane_data;
    logic [3:0]         w_lane_be_n;

    // Address decode and alignment of the presented request
    assign w_in_base = (bus.req_addr[31:22] == 10'h200);
    assign w_in_ext  = (bus.req_addr[31:22] == 10'h201);
    assign w_is_uart = (bus.req_addr == UART_ADDR);

    always_comb begin
        w_aligned   = 1'b0;
        w_lane_data = bus.req_data;
        w_lane_be_n = 4'b0000;
        unique case (bus.req_size)
            2'b00: begin
                w_aligned   = 1'b1;
                w_lane_data = {4{bus.req_data[7:0]}};
                w_lane_be_n = ~(4'b0001 << bus.req_addr[1:0]);
            end
            2'b01: begin
                w_aligned   = ~bus.req_addr[0];
                w_lane_data = {2{bus.req_data[15:0]}};
                w_lane_be_n = bus.req_addr[1] ? 4'b0011 : 4'b1100;
            end
            2'b10: begin
                w_aligned   = (bus.req_addr[1:0] == 2'b00);
                w_lane_data = bus.req_data;
                w_lane_be_n = 4'b0000;
            end
            default: begin
                w_aligned   = 1'b0;
                w_lane_data = bus.req_data;
                w_lane_be_n = 4'b1111;
            end
        endcase
    end

    // UART takes byte stores only; everything else must hit an SRAM window aligned
    assign w_fault = w_is_uart ? (bus.req_size != 2'b00)
                               : (!(w_in_base || w_in_ext) || !w_aligned);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_be_n_nxt   = r_be_n;
        w_uwdata_nxt = r_uwdata;
        w_use_nxt    = r_use;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_addr_nxt   = bus.req_addr[21:2];
                    w_wdata_nxt  = w_lane_data;
                    w_uwdata_nxt = bus.req_data[7:0];
                    w_use_nxt    = w_is_uart ? c_USE_UART :
                                   (w_in_ext ? c_USE_EXT : c_USE_BASE);
                    if (w_fault) begin
                        w_state_nxt = S_FAULT;
                    end else if (w_is_uart) begin
                        w_state_nxt = S_U_WAIT;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_be_n_nxt  = w_lane_be_n;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt = S_WRITE;
                w_cnt_nxt   = '0;
            end
            S_WRITE: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
                w_be_n_nxt  = 4'b1111;
            end
            S_U_WAIT: begin
                if (bus.uart_tx_ready) begin
                    w_state_nxt = S_U_WR;
                end
            end
            S_U_WR:   w_state_nxt = S_U_HOLD;
            S_U_HOLD: w_state_nxt = S_IDLE;
            S_FAULT:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        // Strobes are registered from the state being entered, so they line up with it
        w_ce_n_nxt = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_WRITE) ||
                       (w_state_nxt == S_HOLD));
        w_we_n_nxt = (w_state_nxt != S_WRITE);
        w_wr_n_nxt = (w_state_nxt != S_U_WR);
        w_done_nxt = (w_state_nxt == S_HOLD) || (w_state_nxt == S_U_HOLD) ||
                     (w_state_nxt == S_FAULT);
        w_err_nxt  = (w_state_nxt == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be_n   <= 4'b1111;
            r_uwdata <= '0;
            r_use    <= c_USE_BASE;
            r_ce_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_be_n   <= w_be_n_nxt;
            r_uwdata <= w_uwdata_nxt;
            r_use    <= w_use_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_wr_n   <= w_wr_n_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.mem_use    = r_use;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_wdata  = r_wdata;
    assign bus.ram_be_n   = r_be_n;
    assign bus.ram_ce_n   = r_ce_n;
    assign bus.ram_we_n   = r_we_n;
    assign bus.ram_oe_n   = 1'b1;
    assign bus.uart_wr_n  = r_wr_n;
    assign bus.uart_wdata = r_uwdata;
endmodule

`default_nettype wire
